// File: rtl/rob_pkg.sv
// rob_pkg: rob pointer and writeback entry types shared by the rob and the writeback arbiter.
`ifndef ROB_SIZE_LOG
`define ROB_SIZE_LOG 5
`endif
package rob_pkg;
   localparam int ROB_W = `ROB_SIZE_LOG;
   typedef struct packed {
      logic             flag;
      logic [ROB_W-1:0] idx;
   } rob_ptr_t;
   typedef struct packed {
      rob_ptr_t ptr;
      logic     need_to_wb;
   } wb_entry_t;
   function automatic logic rob_is_younger(rob_ptr_t e, rob_ptr_t r);
      return (e.flag == r.flag) ? (e.idx > r.idx) : (e.idx < r.idx);
   endfunction
endpackage

// File: rtl/wb_req_buf.sv
// wb_req_buf: per-requester completion FIFO, head at slot 0, with age-based flush and compaction.
module wb_req_buf
   import rob_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic      clock,
   input  logic      reset_n,
   input  logic      push,
   input  wb_entry_t push_data,
   input  logic      pop,
   input  logic      flush,
   input  rob_ptr_t  flush_ptr,
   output wb_entry_t head,
   output logic      empty,
   output logic      full
);
   localparam int CW = $clog2(DEPTH) + 1;
   wb_entry_t mem [DEPTH];
   wb_entry_t nxt [DEPTH];
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   assign head  = mem[0];
   assign empty = cnt == '0;
   assign full  = cnt == CW'(DEPTH);
   // Survivors are re-packed from slot 0 so the oldest surviving entry is always the head.
   always_comb begin : p_next
      int n;
      n = 0;
      nxt = mem;
      for (int i = 0; i < DEPTH; i++)
         if (i >= int'(pop) && i < int'(cnt) && !(flush && rob_is_younger(mem[i].ptr, flush_ptr))) begin
            nxt[n] = mem[i];
            n++;
         end
      if (push && !(flush && rob_is_younger(push_data.ptr, flush_ptr))) begin
         nxt[n] = push_data;
         n++;
      end
      cnt_nxt = CW'(n);
   end
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         cnt <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         cnt <= cnt_nxt;
         mem <= nxt;
      end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin scheduler of NUM_REQ completion buffers onto three registered rob writeback ports.
// Optional WB_ARB_PERF_EN adds saturating stall and conflict counters.
module wb_arbiter
   import rob_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int BUF_DEPTH = 2
) (
   input  logic                     clock,
   input  logic                     reset_n,
`ifdef WB_ARB_PERF_EN
   output logic [31:0]              perf_stall_cnt,
   output logic [31:0]              perf_conflict_cnt,
`endif
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ-1:0]       req_robflag,
   input  logic [NUM_REQ*ROB_W-1:0] req_robidx,
   input  logic [NUM_REQ-1:0]       req_need_to_wb,
   output logic                     writebacks0_valid,
   output logic                     writebacks0_robflag,
   output logic [ROB_W-1:0]         writebacks0_robidx,
   output logic                     writebacks0_need_to_wb,
   output logic                     writebacks1_valid,
   output logic                     writebacks1_robflag,
   output logic [ROB_W-1:0]         writebacks1_robidx,
   output logic                     writebacks1_need_to_wb,
   output logic                     writebacks2_valid,
   output logic                     writebacks2_robflag,
   output logic [ROB_W-1:0]         writebacks2_robidx,
   output logic                     writebacks2_need_to_wb,
   input  logic                     redirect_valid,
   input  logic                     redirect_robflag,
   input  logic [ROB_W-1:0]         redirect_robidx
);
   localparam int PW = $clog2(NUM_REQ);
   logic [NUM_REQ-1:0] empty;
   logic [NUM_REQ-1:0] full;
   logic [NUM_REQ-1:0] push;
   logic [NUM_REQ-1:0] pop;
   wb_entry_t in_ent [NUM_REQ];
   wb_entry_t head [NUM_REQ];
   rob_ptr_t redir;
   logic [PW-1:0] rr_ptr;
   logic [PW-1:0] rr_nxt;
   logic [2:0] slot_v;
   logic [2:0] keep;
   logic [PW-1:0] slot_r [3];
   logic [2:0] wb_v;
   wb_entry_t wb_q [3];
   assign redir     = '{flag: redirect_robflag, idx: redirect_robidx};
   assign req_ready = ~full;
   assign push      = req_valid & ~full;
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_buf
      assign in_ent[i] = '{ptr: '{flag: req_robflag[i], idx: req_robidx[i*ROB_W +: ROB_W]},
                           need_to_wb: req_need_to_wb[i]};
      wb_req_buf #(.DEPTH(BUF_DEPTH)) u_buf (
         .clock     (clock),
         .reset_n   (reset_n),
         .push      (push[i]),
         .push_data (in_ent[i]),
         .pop       (pop[i]),
         .flush     (redirect_valid),
         .flush_ptr (redir),
         .head      (head[i]),
         .empty     (empty[i]),
         .full      (full[i])
      );
   end
   // Scan from rr_ptr; the first three non-empty heads take slots 0..2 in scan order.
   always_comb begin : p_scan
      int r;
      int n;
      n = 0;
      slot_v = '0;
      pop = '0;
      rr_nxt = rr_ptr;
      for (int s = 0; s < 3; s++) slot_r[s] = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         r = (int'(rr_ptr) + k) % NUM_REQ;
         if (!empty[r] && n < 3) begin
            slot_v[n] = 1'b1;
            slot_r[n] = PW'(r);
            pop[r] = 1'b1;
            rr_nxt = PW'((r + 1) % NUM_REQ);
            n++;
         end
      end
      for (int s = 0; s < 3; s++)
         keep[s] = slot_v[s] && !(redirect_valid && rob_is_younger(head[slot_r[s]].ptr, redir));
   end
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         rr_ptr <= '0;
         wb_v <= '0;
         for (int s = 0; s < 3; s++) wb_q[s] <= '0;
      end else begin
         rr_ptr <= rr_nxt;
         wb_v <= keep;
         for (int s = 0; s < 3; s++) wb_q[s] <= keep[s] ? head[slot_r[s]] : '0;
      end
   assign writebacks0_valid      = wb_v[0];
   assign writebacks0_robflag    = wb_q[0].ptr.flag;
   assign writebacks0_robidx     = wb_q[0].ptr.idx;
   assign writebacks0_need_to_wb = wb_q[0].need_to_wb;
   assign writebacks1_valid      = wb_v[1];
   assign writebacks1_robflag    = wb_q[1].ptr.flag;
   assign writebacks1_robidx     = wb_q[1].ptr.idx;
   assign writebacks1_need_to_wb = wb_q[1].need_to_wb;
   assign writebacks2_valid      = wb_v[2];
   assign writebacks2_robflag    = wb_q[2].ptr.flag;
   assign writebacks2_robidx     = wb_q[2].ptr.idx;
   assign writebacks2_need_to_wb = wb_q[2].need_to_wb;
`ifdef WB_ARB_PERF_EN
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         perf_stall_cnt <= '0;
         perf_conflict_cnt <= '0;
      end else begin
         if (|(req_valid & full) && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 32'd1;
         if ($countones(~empty) > 3 && perf_conflict_cnt != '1) perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
      end
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed and random checks of wb_arbiter against a queue-based reference model.
module tb_wb_arbiter;
   import rob_pkg::*;
   localparam int NR = 4;
   localparam int DEPTH = 2;
   localparam int W = ROB_W;
   logic clock = 1'b0;
   logic reset_n = 1'b0;
   logic [NR-1:0] req_valid = '0, req_ready, req_robflag = '0, req_need_to_wb = '0;
   logic [NR*W-1:0] req_robidx = '0;
   logic redirect_valid = 1'b0, redirect_robflag = 1'b0;
   logic [W-1:0] redirect_robidx = '0;
   logic wv [3];
   logic wf [3];
   logic [W-1:0] wi [3];
   logic ww [3];
`ifdef WB_ARB_PERF_EN
   logic [31:0] perf_stall_cnt, perf_conflict_cnt;
   logic [31:0] m_stall = 0, m_conf = 0;
`endif
   int checks = 0;
   int errors = 0;
   wb_entry_t mq [NR][$];
   int rr_m = 0;
   logic ev [3];
   logic eunf [3];
   wb_entry_t ed [3];
   always #5 clock = ~clock;
   wb_arbiter #(.NUM_REQ(NR), .BUF_DEPTH(DEPTH)) dut (
      .clock(clock), .reset_n(reset_n),
`ifdef WB_ARB_PERF_EN
      .perf_stall_cnt(perf_stall_cnt), .perf_conflict_cnt(perf_conflict_cnt),
`endif
      .req_valid(req_valid), .req_ready(req_ready), .req_robflag(req_robflag),
      .req_robidx(req_robidx), .req_need_to_wb(req_need_to_wb),
      .writebacks0_valid(wv[0]), .writebacks0_robflag(wf[0]), .writebacks0_robidx(wi[0]), .writebacks0_need_to_wb(ww[0]),
      .writebacks1_valid(wv[1]), .writebacks1_robflag(wf[1]), .writebacks1_robidx(wi[1]), .writebacks1_need_to_wb(ww[1]),
      .writebacks2_valid(wv[2]), .writebacks2_robflag(wf[2]), .writebacks2_robidx(wi[2]), .writebacks2_need_to_wb(ww[2]),
      .redirect_valid(redirect_valid), .redirect_robflag(redirect_robflag), .redirect_robidx(redirect_robidx)
   );
   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask
   // Position on a 2^(W+1) circle; younger means 1..2^W-1 steps ahead of the redirect.
   function automatic bit young(rob_ptr_t e, rob_ptr_t r);
      int m = 1 << (W + 1);
      int d = ((int'(e.flag) * (1 << W) + int'(e.idx)) - (int'(r.flag) * (1 << W) + int'(r.idx)) + m) % m;
      return d >= 1 && d < (1 << W);
   endfunction
   task automatic model_clear();
      for (int r = 0; r < NR; r++) mq[r].delete();
      rr_m = 0;
      for (int s = 0; s < 3; s++) begin ev[s] = 0; eunf[s] = 1; ed[s] = '0; end
`ifdef WB_ARB_PERF_EN
      m_stall = 0; m_conf = 0;
`endif
   endtask
   task automatic model_step();
      logic [NR-1:0] rdy;
      int ns = 0, last = 0, cand = 0;
      wb_entry_t e, q[$];
      rob_ptr_t rd = '{flag: redirect_robflag, idx: redirect_robidx};
      for (int r = 0; r < NR; r++) begin
         rdy[r] = mq[r].size() < DEPTH;
         if (mq[r].size() > 0) cand++;
      end
`ifdef WB_ARB_PERF_EN
      if (|(req_valid & ~rdy) && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (cand > 3 && m_conf != 32'hFFFF_FFFF) m_conf++;
`endif
      for (int k = 0; k < NR; k++) begin
         int r = (rr_m + k) % NR;
         if (mq[r].size() > 0 && ns < 3) begin
            e = mq[r].pop_front();
            ev[ns] = !(redirect_valid && young(e.ptr, rd));
            ed[ns] = ev[ns] ? e : '0;
            eunf[ns] = 0;
            ns++;
            last = r;
         end
      end
      for (int s = ns; s < 3; s++) begin ev[s] = 0; eunf[s] = 1; ed[s] = '0; end
      if (ns > 0) rr_m = (last + 1) % NR;
      if (redirect_valid)
         for (int r = 0; r < NR; r++) begin
            q = {};
            foreach (mq[r][j]) if (!young(mq[r][j].ptr, rd)) q.push_back(mq[r][j]);
            mq[r] = q;
         end
      for (int r = 0; r < NR; r++) begin
         e = '{ptr: '{flag: req_robflag[r], idx: req_robidx[r*W +: W]}, need_to_wb: req_need_to_wb[r]};
         if (req_valid[r] && rdy[r] && !(redirect_valid && young(e.ptr, rd))) mq[r].push_back(e);
      end
   endtask
   // Called at posedge+1 with inputs set: checks ready, advances model, checks registered outputs.
   task automatic tick();
      logic [NR-1:0] mr;
      for (int r = 0; r < NR; r++) mr[r] = mq[r].size() < DEPTH;
      chk("req_ready", 64'(req_ready), 64'(mr));
      model_step();
      @(posedge clock);
      #1;
      for (int s = 0; s < 3; s++) begin
         chk($sformatf("wb%0d_valid", s), 64'(wv[s]), 64'(ev[s]));
         if (ev[s] || eunf[s])
            chk($sformatf("wb%0d_fields", s), 64'({wf[s], wi[s], ww[s]}), 64'({ed[s].ptr.flag, ed[s].ptr.idx, ed[s].need_to_wb}));
      end
`ifdef WB_ARB_PERF_EN
      chk("perf_stall", 64'(perf_stall_cnt), 64'(m_stall));
      chk("perf_conflict", 64'(perf_conflict_cnt), 64'(m_conf));
`endif
   endtask
   task automatic set_req(int i, logic v, logic f, int idx, logic wb);
      req_valid[i] = v;
      req_robflag[i] = f;
      req_robidx[i*W +: W] = W'(idx);
      req_need_to_wb[i] = wb;
   endtask
   task automatic clear_in();
      req_valid = '0;
      redirect_valid = 0;
   endtask
   task automatic do_reset();
      clear_in();
      #2 reset_n = 0;
      #1;
      for (int s = 0; s < 3; s++) chk($sformatf("rst_wb%0d", s), 64'({wv[s], wf[s], wi[s], ww[s]}), 64'(0));
      chk("rst_ready", 64'(req_ready), 64'({NR{1'b1}}));
      model_clear();
      @(posedge clock);
      #1 reset_n = 1;
   endtask
   initial begin
      bit saw2;
      model_clear();
      @(posedge clock);
      #1 reset_n = 1;
      // 1: single completion, latency two cycles
      do_reset();
      set_req(0, 1, 0, 5, 1);
      tick();
      clear_in();
      tick();
      chk("t1_wb0", 64'({wv[0], wf[0], wi[0], ww[0]}), 64'({1'b1, 1'b0, W'(5), 1'b1}));
      chk("t1_wb1_v", 64'(wv[1]), 64'(0));
      chk("t1_wb2_v", 64'(wv[2]), 64'(0));
      // 2: all four at once from rr_ptr=0
      do_reset();
      for (int i = 0; i < NR; i++) set_req(i, 1, 0, 10 + i, i[0]);
      tick();
      clear_in();
      tick();
      chk("t2_slots", 64'({wv[0], wi[0], wv[1], wi[1], wv[2], wi[2]}),
          64'({1'b1, W'(10), 1'b1, W'(11), 1'b1, W'(12)}));
      tick();
      chk("t2_next", 64'({wv[0], wi[0], wv[1], wv[2]}), 64'({1'b1, W'(13), 1'b0, 1'b0}));
      // 3: back-to-back on req1 with no stall
      do_reset();
      set_req(1, 1, 0, 20, 0);
      chk("t3_rdy_a", 64'(req_ready[1]), 64'(1));
      tick();
      set_req(1, 1, 0, 21, 0);
      chk("t3_rdy_b", 64'(req_ready[1]), 64'(1));
      tick();
      chk("t3_out_a", 64'({wv[0], wi[0]}), 64'({1'b1, W'(20)}));
      set_req(1, 1, 0, 22, 0);
      chk("t3_rdy_c", 64'(req_ready[1]), 64'(1));
      tick();
      chk("t3_out_b", 64'({wv[0], wi[0]}), 64'({1'b1, W'(21)}));
      clear_in();
      tick();
      chk("t3_out_c", 64'({wv[0], wi[0]}), 64'({1'b1, W'(22)}));
      // 4: four streams into three ports fill req2
      do_reset();
      saw2 = 0;
      for (int c = 0; c < 8; c++) begin
         for (int i = 0; i < NR; i++) set_req(i, 1, 0, c * 4 + i, 1);
         if (!req_ready[2]) saw2 = 1;
         tick();
      end
      chk("t4_req2_full_seen", 64'(saw2), 64'(1));
      clear_in();
      tick();
      // 5: redirect at idx7 drops idx9 but keeps 3 and 7
      do_reset();
      set_req(0, 1, 0, 3, 1);
      set_req(1, 1, 0, 7, 1);
      tick();
      clear_in();
      set_req(0, 1, 0, 9, 1);
      redirect_valid = 1; redirect_robflag = 0; redirect_robidx = W'(7);
      tick();
      clear_in();
      chk("t5_slots", 64'({wv[0], wi[0], wv[1], wi[1], wv[2]}), 64'({1'b1, W'(3), 1'b1, W'(7), 1'b0}));
      tick();
      chk("t5_after", 64'({wv[0], wv[1], wv[2]}), 64'(0));
      // 6: wrap-flag flush
      do_reset();
      set_req(3, 1, 1, 1, 1);
      tick();
      clear_in();
      redirect_valid = 1; redirect_robflag = 0; redirect_robidx = W'(30);
      tick();
      clear_in();
      chk("t6_flushed", 64'({wv[0], wv[1], wv[2]}), 64'(0));
      tick();
      chk("t6_after", 64'({wv[0], wv[1], wv[2]}), 64'(0));
      // random phase with a mid-stream reset
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if (c == 1500) do_reset();
         for (int i = 0; i < NR; i++)
            set_req(i, $urandom_range(0, 9) < 6, 1'($urandom), int'($urandom_range(0, (1 << W) - 1)), 1'($urandom));
         redirect_valid = $urandom_range(0, 7) == 0;
         redirect_robflag = 1'($urandom);
         redirect_robidx = W'($urandom);
         tick();
      end
      clear_in();
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
